// File: rtl/div_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : div_ctrl_if
// Brief    : EX-stage request/response bundle for the multi-cycle divider.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface div_ctrl_if #(
   parameter int DATA_W = 32
);
   logic                  start;
   logic                  signed_div;
   logic                  annul;
   logic [DATA_W-1:0]     opdata1;
   logic [DATA_W-1:0]     opdata2;
   logic                  stall;
   logic                  ready;
   logic [2*DATA_W-1:0]   result;

   modport master (
      output start, signed_div, annul, opdata1, opdata2,
      input  stall, ready, result
   );

   modport slave (
      input  start, signed_div, annul, opdata1, opdata2,
      output stall, ready, result
   );
endinterface

`default_nettype wire

// File: rtl/div_ctrl.sv
//------------------------------------------------------------------------------
// Module   : div_ctrl
// Brief    : Radix-2 restoring DIV/DIVU sequencer producing {HI, LO} = {rem, quo}.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_ctrl #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic        clk,
   input  logic        resetn,
   div_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DIVZERO = 2'd1,
      S_BUSY    = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DATA_W - 1);

   state_t                r_state;
   state_t                w_next;

   logic [DATA_W-1:0]     r_rem;
   logic [DATA_W-1:0]     r_quo;
   logic [DATA_W-1:0]     r_div;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_signed;
   logic                  r_sign_q;
   logic                  r_sign_r;
   logic                  r_ready;
   logic [2*DATA_W-1:0]   r_result;

   logic                  w_zero;
   logic [DATA_W-1:0]     w_op1_abs;
   logic [DATA_W-1:0]     w_op2_abs;
   logic [DATA_W:0]       w_shift;
   logic [DATA_W:0]       w_diff;
   logic                  w_ge;
   logic [DATA_W-1:0]     w_quo_fix;
   logic [DATA_W-1:0]     w_rem_fix;

   assign w_zero    = (bus.opdata2 == '0);
   assign w_op1_abs = (bus.signed_div && bus.opdata1[DATA_W-1]) ? -bus.opdata1 : bus.opdata1;
   assign w_op2_abs = (bus.signed_div && bus.opdata2[DATA_W-1]) ? -bus.opdata2 : bus.opdata2;

   // w_shift < 2*divisor, so the (DATA_W+1)-bit difference never overflows its sign bit
   assign w_shift = {r_rem, r_quo[DATA_W-1]};
   assign w_diff  = w_shift - {1'b0, r_div};
   assign w_ge    = ~w_diff[DATA_W];

   assign w_quo_fix = (r_signed && r_sign_q) ? -r_quo : r_quo;
   assign w_rem_fix = (r_signed && r_sign_r) ? -r_rem : r_rem;

   assign bus.stall  = bus.start & ~r_ready & ~bus.annul;
   assign bus.ready  = r_ready;
   assign bus.result = r_result;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (bus.annul) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  w_next = w_zero ? S_DIVZERO : S_BUSY;
               end
            end
            S_BUSY: begin
               if (r_cnt == c_last_cnt) begin
                  w_next = S_DONE;
               end
            end
            S_DIVZERO: begin
               w_next = S_DONE;
            end
            S_DONE: begin
               if (!bus.start) begin
                  w_next = S_IDLE;
               end
            end
            default: begin
               w_next = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_cnt    <= '0;
         r_signed <= 1'b0;
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_ready  <= 1'b0;
         r_result <= '0;
      end else if (bus.annul) begin
         r_ready  <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  // A zero divisor clears everything so the DONE fixup yields 0
                  r_rem    <= '0;
                  r_cnt    <= '0;
                  r_div    <= w_zero ? '0 : w_op2_abs;
                  r_quo    <= w_zero ? '0 : w_op1_abs;
                  r_signed <= bus.signed_div & ~w_zero;
                  r_sign_q <= bus.opdata1[DATA_W-1] ^ bus.opdata2[DATA_W-1];
                  r_sign_r <= bus.opdata1[DATA_W-1];
               end
            end
            S_BUSY: begin
               r_rem <= w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
               r_quo <= {r_quo[DATA_W-2:0], w_ge};
               r_cnt <= r_cnt + 1'b1;
            end
            S_DONE: begin
               if (bus.start) begin
                  r_ready  <= 1'b1;
                  r_result <= {w_rem_fix, w_quo_fix};
               end else begin
                  r_ready  <= 1'b0;
                  r_result <= '0;
               end
            end
            default: begin
               r_ready <= r_ready;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_div_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_div_ctrl
// Brief    : Scoreboard bench for div_ctrl with directed and random divides.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_div_ctrl;

   localparam int W = 32;

   logic clk = 1'b0;
   logic resetn;

   always #5 clk = ~clk;

   div_ctrl_if #(.DATA_W(W)) bus ();

   div_ctrl #(
      .DATA_W (W),
      .CNT_W  (6)
   ) u_dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int            checks   = 0;
   int            failures = 0;
   logic [2*W-1:0] sb_q[$];
   logic          prev_ready = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Reference: plain integer division, truncating toward zero
   function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      if (b == 32'd0) return 64'd0;
      if (!s) return {a % b, a / b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = a;
      sb = b;
      return {32'(sa % sb), 32'(sa / sb)};
   endfunction

   always @(negedge clk) begin
      if (bus.ready === 1'b1 && prev_ready !== 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready: got ready=1 result=%h required no pending result", bus.result);
         end else begin
            chk("result", bus.result, sb_q.pop_front());
         end
      end
      prev_ready = bus.ready;
   end

   task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold);
      logic [63:0] exp;
      int          lat;
      int          k;
      bit          stall_ok;
      exp      = model(s, a, b);
      lat      = (b == 32'd0) ? 2 : W + 1;
      stall_ok = 1'b1;
      sb_q.push_back(exp);
      @(posedge clk);
      #1;
      bus.start      = 1'b1;
      bus.signed_div = s;
      bus.opdata1    = a;
      bus.opdata2    = b;
      @(posedge clk);
      // operands only matter at acceptance
      #1;
      bus.opdata1    = $urandom;
      bus.opdata2    = $urandom;
      bus.signed_div = 1'($urandom);
      k = 0;
      forever begin
         @(negedge clk);
         if (bus.ready === 1'b1 || k >= 200) break;
         if (bus.stall !== 1'b1) stall_ok = 1'b0;
         @(posedge clk);
         k++;
      end
      chk("latency", 64'(k), 64'(lat));
      chk("stall_while_busy", 64'(stall_ok), 64'd1);
      chk("stall_at_ready", 64'(bus.stall), 64'd0);
      repeat (hold) begin
         @(posedge clk);
         @(negedge clk);
         chk("hold_ready", 64'(bus.ready), 64'd1);
         chk("hold_result", bus.result, exp);
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("idle_ready", 64'(bus.ready), 64'd0);
      chk("idle_result", bus.result, 64'd0);
      chk("idle_stall", 64'(bus.stall), 64'd0);
   endtask

   task automatic abort_op(input bit use_reset, input int at_cycle,
                           input logic [31:0] a, input logic [31:0] b, input bit reaches_done);
      if (reaches_done) sb_q.push_back(model(1'b0, a, b));
      @(posedge clk);
      #1;
      bus.start      = 1'b1;
      bus.signed_div = 1'b0;
      bus.opdata1    = a;
      bus.opdata2    = b;
      @(posedge clk);
      repeat (at_cycle) @(posedge clk);
      #1;
      if (use_reset) begin
         resetn    = 1'b0;
         bus.start = 1'b0;
         #1;
         chk("rst_ready", 64'(bus.ready), 64'd0);
         chk("rst_result", bus.result, 64'd0);
         chk("rst_stall", 64'(bus.stall), 64'd0);
         @(posedge clk);
         #1;
         resetn = 1'b1;
      end else begin
         bus.annul = 1'b1;
         #1;
         chk("annul_stall", 64'(bus.stall), 64'd0);
         @(posedge clk);
         #1;
         bus.annul = 1'b0;
         bus.start = 1'b0;
      end
      repeat (3) begin
         @(negedge clk);
         chk("abort_ready", 64'(bus.ready), 64'd0);
         chk("abort_stall", 64'(bus.stall), 64'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit          s;
      logic [31:0] a;
      logic [31:0] b;
      resetn         = 1'b0;
      bus.start      = 1'b0;
      bus.annul      = 1'b0;
      bus.signed_div = 1'b0;
      bus.opdata1    = '0;
      bus.opdata2    = '0;
      @(negedge clk);
      chk("reset_ready", 64'(bus.ready), 64'd0);
      chk("reset_result", bus.result, 64'd0);
      chk("reset_stall", 64'(bus.stall), 64'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;

      do_op(1'b0, 32'd100, 32'd7, 0);
      do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1);
      do_op(1'b0, 32'hFFFF_FFF9, 32'd2, 0);
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
      do_op(1'b0, 32'h1234_5678, 32'd0, 0);
      do_op(1'b1, 32'h8765_4321, 32'd0, 2);

      abort_op(1'b0, 10, 32'd1000, 32'd3, 1'b0);
      do_op(1'b0, 32'd9, 32'd3, 0);
      abort_op(1'b1, 20, 32'd5000, 32'd17, 1'b0);
      do_op(1'b1, 32'hFFFF_FF00, 32'd7, 5);
      abort_op(1'b1, W + 3, 32'd77, 32'd5, 1'b1);
      abort_op(1'b0, W + 2, 32'd88, 32'd6, 1'b1);
      do_op(1'b0, 32'd1, 32'hFFFF_FFFF, 0);

      for (int i = 0; i < 20; i++) begin
         s = 1'($urandom);
         a = (i % 7 == 3) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 4))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         do_op(s, a, b, $urandom_range(0, 3));
      end

      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
